// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the streaming CNN layers (conv, pool, dense).
//   state_t    - layer control states
//   outDim     - output size along one axis, with or without "same" padding
//   accWidth   - accumulator width that cannot overflow for a given tap count
//   cntWidth   - counter width for a bound, never less than 1 bit
//   saturate   - clamp a wide signed value to a signed outW-bit range
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  function automatic int outDim(input int inDim, input int filterDim,
                                input int stride, input int padEn);
    if (padEn != 0) return (inDim - 1) / stride + 1;
    return (inDim - filterDim) / stride + 1;
  endfunction

  // One sign bit of headroom on top of the full product width plus log2(taps).
  function automatic int accWidth(input int bitWidth, input int taps);
    return 2 * bitWidth + $clog2(taps) + 1;
  endfunction

  function automatic int cntWidth(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int outW);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (outW - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (outW - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: signed multiply-accumulate used by conv2d_stream.
//   clear    - load accumulator with the sign-extended bias (has priority)
//   enable   - acc += dataIn * weightIn
//   result   - accumulator saturated to 2*BITWIDTH bits
// Accumulator resets asynchronously to 0, so result is 0 in reset.
module conv_mac import conv_pkg::*; #(
  parameter int BITWIDTH = 8,
  parameter int ACCW     = 22
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         enable,
  input  logic signed [BITWIDTH-1:0]   bias,
  input  logic signed [BITWIDTH-1:0]   dataIn,
  input  logic signed [BITWIDTH-1:0]   weightIn,
  output logic signed [2*BITWIDTH-1:0] result
);

  logic signed [ACCW-1:0]       acc;
  logic signed [2*BITWIDTH-1:0] product;

  // Operands are extended to the full product width before multiplying.
  assign product = dataIn * weightIn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= ACCW'(bias);
    end else if (enable) begin
      acc <= acc + ACCW'(product);
    end
  end

  assign result = (2*BITWIDTH)'(saturate(64'(acc), 2 * BITWIDTH));

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 2-D convolution with one shared MAC.
//   start/filterWeight/filterBias - frame start; weights and bias latched on it
//   in_valid/in_ready/in_data     - input map, order channel, row, column
//   out_valid/out_ready/out_data  - saturated results, order filter, row, column
//   busy                          - state != IDLE
//   done                          - one-cycle pulse after the last result handshake
//   dbgState                      - current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds valid and data stable until that edge, and valid
// never depends combinationally on ready.
module conv2d_stream import conv_pkg::*; #(
  parameter int BITWIDTH      = 8,
  parameter int DATAWIDTH     = 8,
  parameter int DATAHEIGHT    = 8,
  parameter int DATACHANNEL   = 2,
  parameter int FILTERHEIGHT  = 3,
  parameter int FILTERWIDTH   = 3,
  parameter int FILTERBATCH   = 2,
  parameter int STRIDEHEIGHT  = 1,
  parameter int STRIDEWIDTH   = 1,
  parameter int PADDINGENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BITWIDTH*FILTERHEIGHT*FILTERWIDTH*DATACHANNEL*FILTERBATCH-1:0] filterWeight,
  input  logic [BITWIDTH*FILTERBATCH-1:0] filterBias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITWIDTH-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BITWIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output state_t                dbgState
);

  localparam int H    = DATAHEIGHT;
  localparam int W    = DATAWIDTH;
  localparam int C    = DATACHANNEL;
  localparam int FH   = FILTERHEIGHT;
  localparam int FW   = FILTERWIDTH;
  localparam int F    = FILTERBATCH;
  localparam int OH   = outDim(H, FH, STRIDEHEIGHT, PADDINGENABLE);
  localparam int OW   = outDim(W, FW, STRIDEWIDTH, PADDINGENABLE);
  localparam int K    = C * FH * FW;
  localparam int ACCW = accWidth(BITWIDTH, K);
  localparam int NPIX = C * H * W;
  localparam int PADY = (PADDINGENABLE != 0) ? FH / 2 : 0;
  localparam int PADX = (PADDINGENABLE != 0) ? FW / 2 : 0;

  localparam int addrW  = cntWidth(NPIX);
  localparam int wAddrW = cntWidth(K * F);
  localparam int chW    = cntWidth(C);
  localparam int kyW    = cntWidth(FH);
  localparam int kxW    = cntWidth(FW);
  localparam int fW     = cntWidth(F);
  localparam int oyW    = cntWidth(OH);
  localparam int oxW    = cntWidth(OW);

  localparam logic [addrW-1:0] addrLast = addrW'(NPIX - 1);
  localparam logic [chW-1:0]   chLast   = chW'(C - 1);
  localparam logic [kyW-1:0]   kyLast   = kyW'(FH - 1);
  localparam logic [kxW-1:0]   kxLast   = kxW'(FW - 1);
  localparam logic [fW-1:0]    fLast    = fW'(F - 1);
  localparam logic [oyW-1:0]   oyLast   = oyW'(OH - 1);
  localparam logic [oxW-1:0]   oxLast   = oxW'(OW - 1);

  state_t            state;
  logic [addrW-1:0]  loadAddr;
  logic [chW-1:0]    tapC;
  logic [kyW-1:0]    tapKy;
  logic [kxW-1:0]    tapKx;
  logic [fW-1:0]     outF;
  logic [oyW-1:0]    outY;
  logic [oxW-1:0]    outX;
  logic              tapActive;   // 0 = bias-load cycle, 1 = MAC cycles

  logic signed [BITWIDTH-1:0] frameMem  [NPIX];
  logic signed [BITWIDTH-1:0] weightMem [K*F];
  logic signed [BITWIDTH-1:0] biasMem   [F];

  logic signed [BITWIDTH-1:0] tapData;
  logic signed [BITWIDTH-1:0] tapWeight;
  int                         tapY, tapX, rIdx, wIdx;
  logic                       macClear, macEnable;

  // Storage without reset: weights/bias on an accepted start, map on each load beat.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < K * F; i++) weightMem[i] <= filterWeight[i*BITWIDTH +: BITWIDTH];
      for (int i = 0; i < F; i++)     biasMem[i]   <= filterBias[i*BITWIDTH +: BITWIDTH];
    end
    if (state == LOAD && in_valid) frameMem[loadAddr] <= in_data;
  end

  // Tap address generation; map coordinates are in unpadded space, so a
  // negative or too-large coordinate is a padding tap that reads as zero.
  always_comb begin
    tapY = int'(outY) * STRIDEHEIGHT + int'(tapKy) - PADY;
    tapX = int'(outX) * STRIDEWIDTH + int'(tapKx) - PADX;
    rIdx = (int'(tapC) * H + tapY) * W + tapX;
    wIdx = ((int'(outF) * C + int'(tapC)) * FH + int'(tapKy)) * FW + int'(tapKx);
    tapData = '0;
    if (tapY >= 0 && tapY < H && tapX >= 0 && tapX < W) tapData = frameMem[addrW'(rIdx)];
    tapWeight = weightMem[wAddrW'(wIdx)];
  end

  assign macClear  = (state == COMPUTE) && !tapActive;
  assign macEnable = (state == COMPUTE) && tapActive;

  conv_mac #(.BITWIDTH(BITWIDTH), .ACCW(ACCW)) uMac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (macClear),
    .enable   (macEnable),
    .bias     (biasMem[outF]),
    .dataIn   (tapData),
    .weightIn (tapWeight),
    .result   (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      loadAddr  <= '0;
      tapC      <= '0;
      tapKy     <= '0;
      tapKx     <= '0;
      outF      <= '0;
      outY      <= '0;
      outX      <= '0;
      tapActive <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (loadAddr == addrLast) begin
              loadAddr <= '0;
              in_ready <= 1'b0;
              state    <= COMPUTE;
            end else begin
              loadAddr <= loadAddr + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (!tapActive) begin
            tapActive <= 1'b1;
          end else if (tapKx != kxLast) begin
            tapKx <= tapKx + 1'b1;
          end else begin
            tapKx <= '0;
            if (tapKy != kyLast) begin
              tapKy <= tapKy + 1'b1;
            end else begin
              tapKy <= '0;
              if (tapC != chLast) begin
                tapC <= tapC + 1'b1;
              end else begin
                // Last MAC lands on this edge; the result is ready next cycle.
                tapC      <= '0;
                tapActive <= 1'b0;
                out_valid <= 1'b1;
                state     <= OUTPUT;
              end
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COMPUTE;
            if (outX != oxLast) begin
              outX <= outX + 1'b1;
            end else begin
              outX <= '0;
              if (outY != oyLast) begin
                outY <= outY + 1'b1;
              end else begin
                outY <= '0;
                if (outF != fLast) begin
                  outF <= outF + 1'b1;
                end else begin
                  outF  <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_conv2d_stream.sv
`timescale 1ns/1ps
module tb_conv2d_stream;
  import conv_pkg::*;

  localparam int B = 8, H = 8, W = 8, C = 2, FH = 3, FW = 3, F = 2;
  localparam int NPIX = C * H * W;
  localparam int NOUT = F * H * W;
  localparam int K = C * FH * FW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT (padded, stride 1) ----------------
  logic               start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [B-1:0]       in_data;
  logic [2*B-1:0]     out_data;
  logic [B*FH*FW*C*F-1:0] filterWeight;
  logic [B*F-1:0]     filterBias;
  state_t             dbgState;

  conv2d_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .filterWeight(filterWeight),
    .filterBias(filterBias), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .dbgState(dbgState)
  );

  // ---------------- stride DUT (5x5, stride 2, unpadded) ----------------
  logic           sStart, sInValid, sInReady, sOutValid, sBusy, sDone;
  logic           sOutReady = 1'b1;
  logic [B-1:0]   sInData;
  logic [2*B-1:0] sOutData;
  logic [B*9-1:0] sWeight;
  logic [B-1:0]   sBias;
  state_t         sState;

  conv2d_stream #(
    .BITWIDTH(8), .DATAWIDTH(5), .DATAHEIGHT(5), .DATACHANNEL(1),
    .FILTERHEIGHT(3), .FILTERWIDTH(3), .FILTERBATCH(1),
    .STRIDEHEIGHT(2), .STRIDEWIDTH(2), .PADDINGENABLE(0)
  ) sdut (
    .clk(clk), .rst_n(rst_n), .start(sStart), .filterWeight(sWeight),
    .filterBias(sBias), .in_valid(sInValid), .in_ready(sInReady),
    .in_data(sInData), .out_valid(sOutValid), .out_ready(sOutReady),
    .out_data(sOutData), .busy(sBusy), .done(sDone), .dbgState(sState)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0, errors = 0;
  logic [2*B-1:0] exp_q[$];
  logic [2*B-1:0] sexp_q[$];
  int outCount, doneCount, sOutCount, sDoneCount;
  bit bpMode = 1'b0, stalledThis = 1'b0;
  logic [B-1:0] frameData [NPIX];

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : monitor
    logic           prevStall;
    logic [2*B-1:0] prevData, want;
    prevStall = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge clk);
      if (prevStall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, prevData);
      end
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
        end else begin
          want = exp_q.pop_front();
          check("out_data", $signed(out_data), $signed(want));
        end
        outCount++;
        stalledThis = 1'b0;
      end
      if (done) begin
        doneCount++;
        check("done_after_last", exp_q.size(), 0);
      end
    end
  end

  initial begin : sMonitor
    logic [2*B-1:0] want;
    forever begin
      @(negedge clk);
      if (sOutValid && sOutReady) begin
        if (sexp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stride_unexpected: got %0d expected none", $signed(sOutData));
        end else begin
          want = sexp_q.pop_front();
          check("stride_out", $signed(sOutData), $signed(want));
        end
        sOutCount++;
      end
      if (sDone) sDoneCount++;
    end
  end

  // Every third result is held off for 5 cycles when bpMode is set.
  initial begin : readyDriver
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (bpMode && out_valid && !stalledThis && (outCount % 3 == 2)) begin
        stalledThis = 1'b1;
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic set_w(input int f, input int c, input int ky, input int kx, input int v);
    filterWeight[((((f * C + c) * FH + ky) * FW) + kx) * B +: B] = B'(v);
  endtask

  task automatic set_wch(input int f, input int c, input int v);
    for (int ky = 0; ky < FH; ky++)
      for (int kx = 0; kx < FW; kx++) set_w(f, c, ky, kx, v);
  endtask

  task automatic send_frame(input bit stall);
    int idx, cyc;
    logic hs;
    idx = 0;
    cyc = 0;
    while (idx < NPIX && cyc < 4 * NPIX + 100) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = frameData[idx];
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("load_complete", idx, NPIX);
  endtask

  task automatic begin_frame(input bit stall);
    outCount  = 0;
    doneCount = 0;
    in_valid  = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_at_load", busy, 1);
    check("in_ready_at_load", in_ready, 1);
    send_frame(stall);
    check("in_ready_after_load", in_ready, 0);
  endtask

  task automatic run_frame(input bit stall, input bit measure);
    int n;
    begin_frame(stall);
    if (measure) begin
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("first_latency", n, K + 1);
    end
    // Weights are already latched and start is ignored outside IDLE;
    // input beats outside LOAD must not touch the frame buffer.
    filterWeight = ~filterWeight;
    filterBias   = ~filterBias;
    in_valid = 1'b1;
    in_data  = 8'h55;
    start    = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (doneCount == 0 && n < 20000) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    check("done_pulses", doneCount, 1);
    check("outputs_seen", outCount, NOUT);
    check("busy_idle", busy, 0);
    check("state_idle", dbgState, IDLE);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Identity: filter 0 passes channel 0 through, filter 1 passes channel 1 plus 5.
  task automatic setup_identity();
    filterWeight = '0;
    set_w(0, 0, 1, 1, 1);
    set_w(1, 1, 1, 1, 1);
    filterBias = {8'sd5, 8'sd0};
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        frameData[r * W + c]         = B'(r * W + c);
        frameData[H * W + r * W + c] = B'(r * W + c - 100);
      end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(16'(r * W + c));
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(16'(r * W + c - 95));
  endtask

  task automatic run_stride(input bit ramp);
    int idx, n;
    logic hs;
    sOutCount  = 0;
    sDoneCount = 0;
    sWeight = {9{8'h01}};
    sBias   = 8'h01;
    if (ramp) begin
      sexp_q.push_back(16'd55);  sexp_q.push_back(16'd73);
      sexp_q.push_back(16'd145); sexp_q.push_back(16'd163);
    end else begin
      repeat (4) sexp_q.push_back(16'd19);
    end
    @(posedge clk); #1 sStart = 1'b1;
    @(posedge clk); #1 sStart = 1'b0;
    idx = 0;
    n = 0;
    while (idx < 25 && n < 200) begin
      sInValid = 1'b1;
      sInData  = ramp ? B'(idx) : 8'd2;
      @(negedge clk);
      hs = sInValid && sInReady;
      @(posedge clk); #1;
      if (hs) idx++;
      n++;
    end
    sInValid = 1'b0;
    n = 0;
    while (sDoneCount == 0 && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    check("stride_done", sDoneCount, 1);
    check("stride_count", sOutCount, 4);
    check("stride_busy", sBusy, 0);
    check("stride_queue", sexp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    sStart = 1'b0; sInValid = 1'b0; sInData = '0;
    filterWeight = '0; filterBias = '0; sWeight = '0; sBias = '0;
    @(posedge clk); #2;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out_data", out_data, 0);
    check("reset_state", dbgState, IDLE);
    @(negedge clk) rst_n = 1'b1;

    // Identity, with first-result latency
    setup_identity();
    run_frame(1'b0, 1'b1);

    // Channel 0 = 1, channel 1 = -1; f0 cancels, f1 adds 2 per in-map tap
    filterWeight = '0;
    set_wch(0, 0, 1); set_wch(0, 1, 1);
    set_wch(1, 0, 1); set_wch(1, 1, -1);
    filterBias = '0;
    for (int i = 0; i < NPIX; i++) frameData[i] = (i < H * W) ? 8'sd1 : -8'sd1;
    for (int i = 0; i < H * W; i++) exp_q.push_back(16'd0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back(16'(2 * (3 - (r == 0) - (r == H - 1)) * (3 - (c == 0) - (c == W - 1))));
    run_frame(1'b0, 1'b0);

    // Saturation both ways: f0 = -128 * -128 taps + 127, f1 = 127 * -128 taps - 128
    filterWeight = '0;
    set_wch(0, 0, -128); set_wch(0, 1, -128);
    set_wch(1, 0, 127);  set_wch(1, 1, 127);
    filterBias = {8'h80, 8'h7f};
    for (int i = 0; i < NPIX; i++) frameData[i] = 8'h80;
    for (int i = 0; i < H * W; i++) exp_q.push_back(16'h7fff);
    for (int i = 0; i < H * W; i++) exp_q.push_back(16'h8000);
    run_frame(1'b0, 1'b0);

    // Identity again under input stalls and output backpressure
    setup_identity();
    bpMode = 1'b1;
    run_frame(1'b1, 1'b0);
    bpMode = 1'b0;

    // Reset while computing
    setup_identity();
    begin_frame(1'b0);
    n = 0;
    while (outCount < 3 && n < 1000) begin @(negedge clk); n++; end
    check("pre_reset_outputs", outCount, 3);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_state", dbgState, IDLE);
    check("midreset_in_ready", in_ready, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_out_data", out_data, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_done", doneCount, 0);

    // Fresh frame after the abort
    setup_identity();
    run_frame(1'b0, 1'b0);

    // Stride 2, no padding
    run_stride(1'b0);
    run_stride(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
